// File: rtl/regfile_read.sv
// regfile_read: 8 x 8-bit register file read stage with a pending-write
// scoreboard for RAW/WAW hazard detection.
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle
// writeback onto the operand path. That resolves a RAW hazard on the
// written register in the writeback cycle itself. WAW detection is
// identical in both builds.
//
// Handshake: rd_valid is the decode-side valid, and ~stall is this
// stage's ready. An instruction is accepted on a rising edge where
// rd_valid=1 and stall=0. stall is combinational, so decode must hold
// rs_addr/rt_addr/dest_en/dest_addr steady while stalled. Accepted
// operands appear on op_a/op_b with an op_valid pulse exactly one cycle
// later. op_a/op_b hold their values between pulses.

module regfile_read (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_en,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data,
  input  logic       rd_valid,
  input  logic [2:0] rs_addr,
  input  logic [2:0] rt_addr,
  input  logic       dest_en,
  input  logic [2:0] dest_addr,
  output logic       stall,
  output logic       op_valid,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [7:0] pending
);

  // Architectural state
  logic [7:0] r_regs [8];
  logic [7:0] r_pending;
  logic       r_op_valid;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;

  // Combinational helpers
  logic       w_wb_write;
  logic       w_rs_byp;
  logic       w_rt_byp;
  logic [7:0] w_rs_val;
  logic [7:0] w_rt_val;
  logic       w_raw_a;
  logic       w_raw_b;
  logic       w_waw;
  logic       w_stall;
  logic       w_accept;
  logic [7:0] w_clr_mask;
  logic [7:0] w_set_mask;
  logic [7:0] w_pending_nxt;

  // R0 is hardwired to zero, so a writeback to it is a no-op
  assign w_wb_write = wb_en && (wb_addr != 3'd0);

`ifdef REGFILE_BYPASS_EN
  // Same-cycle writeback to a source register supplies that source directly
  assign w_rs_byp = w_wb_write && (wb_addr == rs_addr);
  assign w_rt_byp = w_wb_write && (wb_addr == rt_addr);
`else
  // Without forwarding the array is the only operand source; a dependent
  // instruction waits until the pending bit has been cleared
  assign w_rs_byp = 1'b0;
  assign w_rt_byp = 1'b0;
`endif

  // Operand select and hazard detection
  always_comb begin
    w_rs_val = 8'h00;
    w_rt_val = 8'h00;
    w_raw_a  = 1'b0;
    w_raw_b  = 1'b0;
    w_waw    = 1'b0;
    if (rs_addr != 3'd0) begin
      w_rs_val = w_rs_byp ? wb_data : r_regs[rs_addr];
      w_raw_a  = r_pending[rs_addr] && !w_rs_byp;
    end
    if (rt_addr != 3'd0) begin
      w_rt_val = w_rt_byp ? wb_data : r_regs[rt_addr];
      w_raw_b  = r_pending[rt_addr] && !w_rt_byp;
    end
    if (dest_en && (dest_addr != 3'd0)) begin
      w_waw = r_pending[dest_addr];
    end
  end

  assign w_stall  = rd_valid && (w_raw_a || w_raw_b || w_waw);
  assign w_accept = rd_valid && !w_stall;

  // Scoreboard update: clear on writeback, then set on accept so set wins
  always_comb begin
    w_clr_mask = 8'h00;
    w_set_mask = 8'h00;
    if (wb_en) begin
      w_clr_mask = 8'h01 << wb_addr;
    end
    if (w_accept && dest_en && (dest_addr != 3'd0)) begin
      w_set_mask = 8'h01 << dest_addr;
    end
    w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & 8'hFE;
  end

  // Register array write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_wb_write) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Pending-write scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 8'h00;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Operand output registers: load on accept, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_valid <= 1'b0;
      r_op_a     <= 8'h00;
      r_op_b     <= 8'h00;
    end else begin
      r_op_valid <= w_accept;
      if (w_accept) begin
        r_op_a <= w_rs_val;
        r_op_b <= w_rt_val;
      end
    end
  end

  assign stall    = w_stall;
  assign op_valid = r_op_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign pending  = r_pending;

endmodule

// File: doc/regfile_read.md
REGFILE_READ -- requirements
Module: regfile_read

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-003 SHALL have port: wb_en  input  1  writeback write strobe from the write-back stage.
REQ-004 SHALL have port: wb_addr  input  3  writeback destination register.
REQ-005 SHALL have port: wb_data  input  8  writeback result value.
REQ-006 SHALL have port: rd_valid  input  1  decode presents an instruction for operand read.
REQ-007 SHALL have port: rs_addr  input  3  source register A.
REQ-008 SHALL have port: rt_addr  input  3  source register B.
REQ-009 SHALL have port: dest_en  input  1  instruction will write a register.
REQ-010 SHALL have port: dest_addr  input  3  that instruction's destination register.
REQ-011 SHALL have port: stall  output  1  combinational; instruction not accepted this cycle.
REQ-012 SHALL have port: op_valid  output  1  registered; one-cycle pulse per accepted instruction.
REQ-013 SHALL have port: op_a  output  8  registered operand A.
REQ-014 SHALL have port: op_b  output  8  registered operand B.
REQ-015 SHALL have port: pending  output  8  scoreboard; bit n set = write to Rn in flight.

Function
REQ-016 SHALL hold 8 registers of 8 bits; R0 reads 0 always, writes to R0 ignored.
REQ-017 SHALL write wb_data to wb_addr on the clock edge when wb_en=1 and wb_addr!=0.
REQ-018 SHALL clear pending[wb_addr] on the edge where wb_en=1.
REQ-019 SHALL accept the instruction on an edge where rd_valid=1 and stall=0.
REQ-020 SHALL assert stall when rd_valid=1 and any hazard holds: RAW (a nonzero rs/rt with its pending bit set) or WAW (dest_en=1, dest_addr!=0, pending[dest_addr] set).
REQ-021 SHALL force stall=0 when rd_valid=0.
REQ-022 SHALL, on accept, set pending[dest_addr] when dest_en=1 and dest_addr!=0.
REQ-023 SHALL let set win when accept-set and writeback-clear hit the same bit on the same edge.
REQ-024 SHALL, on accept, load op_a/op_b with the rs/rt values and pulse op_valid=1 the following cycle; latency is exactly one cycle.
REQ-025 SHALL hold op_a/op_b at their last values while op_valid=0.
REQ-026 SHALL never set pending[0].

Reset
REQ-027 SHALL, while reset=1, drive op_valid=0, op_a=0, op_b=0, pending=0 and clear all 8 registers, regardless of clk.
REQ-028 SHALL perform no register write and no accept while reset=1; an in-flight write or accept in that cycle is discarded.
REQ-029 SHALL accept the first instruction on the first rising edge after reset falls when no hazard exists.

Configuration
REQ-030 SHALL support macro REGFILE_BYPASS_EN.
REQ-031 SHALL, with REGFILE_BYPASS_EN defined, treat a same-cycle writeback (wb_en=1, wb_addr!=0) matching rs/rt as resolving that RAW hazard and supply wb_data as the operand.
REQ-032 SHALL, without REGFILE_BYPASS_EN, ignore same-cycle writeback for hazard and operand selection, so a RAW-dependent instruction stalls exactly one more cycle and reads the updated array value.
REQ-033 SHALL apply the same WAW stall rule whether or not REGFILE_BYPASS_EN is defined.

Verification
REQ-034 SHALL cover: reset, write R3=0x5A via wb, then read rs=3, rt=0 -> next cycle op_valid=1, op_a=0x5A, op_b=0x00.
REQ-035 SHALL cover: write R0=0xFF, then read rs=0 -> op_a=0x00, pending[0]=0.
REQ-036 SHALL cover: accept dest=R2, then next instruction rs=2 -> stall=1 until wb R2=0x11; bypass build accepts in the wb cycle with op_a=0x11; non-bypass build accepts one cycle later with op_a=0x11.
REQ-037 SHALL cover: accept dest=R4 with pending[4] set -> stall=1 (WAW); wb R4 -> accept on following edge and pending[4] stays 1.
REQ-038 SHALL cover: same-edge accept dest=R5 and wb R5 -> pending[5]=1 after the edge.
REQ-039 SHALL cover: assert reset asynchronously mid-stall with pending=0x14 -> pending=0, op_valid=0, registers read 0 after release.
